usb_io_regs: RTL and testbench

Parametrised multi-channel register bridge between the Dragon USB FIFO byte interface (USB_D, USB_FWRn, USB_FRDn) and fabric logic. A command-byte protocol lets the host write N_CH output registers and read N_CH synchronised input ports of CH_W bits each, byte-serialised over the 8-bit USB bus. It is the multi-channel, wide-word successor of the 8-pin single-register USB I/O block: outputs update atomically, input reads are tear-free snapshots, and the block carries per-channel commit strobes and error reporting.

---
 rtl/usb_io_pkg.sv | 16 +
 rtl/usb_io_regs_if.sv | 22 ++
 rtl/usb_io_sync2.sv | 24 ++
 rtl/usb_io_regs.sv | 141 ++++++++++++++
 tb/tb_usb_io_regs.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/usb_io_pkg.sv
// rtl/usb_io_pkg.sv - shared constants, FSM states and byte-count helper for usb_io_regs
package usb_io_pkg;

  localparam int CMD_WR_BIT = 7;
  localparam int CMD_CH_MSB = 6;

  typedef enum logic {
    S_CMD   = 1'b0,
    S_WDATA = 1'b1
  } state_t;

  function automatic int nb_of(input int ch_w);
    return (ch_w + 7) / 8;
  endfunction

endpackage

// File: rtl/usb_io_regs_if.sv
// rtl/usb_io_regs_if.sv - USB FIFO strobes and fabric-side register ports of usb_io_regs
interface usb_io_regs_if #(
  parameter int N_CH = 4,
  parameter int CH_W = 16
);
  logic                   USB_FWRn;
  logic                   USB_FRDn;
  logic [N_CH*CH_W-1:0]   dataout;
  logic [N_CH-1:0]        dataout_stb;
  logic [N_CH*CH_W-1:0]   datain;
  logic                   cmd_err;

  modport master (
    output USB_FWRn, USB_FRDn, datain,
    input  dataout, dataout_stb, cmd_err
  );

  modport slave (
    input  USB_FWRn, USB_FRDn, datain,
    output dataout, dataout_stb, cmd_err
  );
endinterface

// File: rtl/usb_io_sync2.sv
// rtl/usb_io_sync2.sv - parametrised-width two-flop synchroniser, async reset to zero
module usb_io_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/usb_io_regs.sv
// rtl/usb_io_regs.sv - multi-channel command-byte register bridge on the USB FIFO byte bus
module usb_io_regs
  import usb_io_pkg::*;
#(
  parameter int              N_CH      = 4,
  parameter int              CH_W      = 16,
  parameter logic [CH_W-1:0] RESET_VAL = '0
) (
  input  logic           CLK_USB,
  input  logic           RST,
  inout  wire  [7:0]     USB_D,
  usb_io_regs_if.slave   bus
);
  localparam int            NB   = nb_of(CH_W);
  localparam int            BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int            DW   = N_CH * CH_W;
  localparam logic [BW-1:0] LAST = BW'(NB - 1);

  state_t            r_state, w_state_nxt;
  logic [6:0]        r_ch, r_rch;
  logic              r_wvalid, r_cmd_err;
  logic [BW-1:0]     r_wbyte, r_rbyte;
  logic [NB*8-1:0]   r_shadow, r_snapshot, w_commit, w_snap_nxt;
  logic [DW-1:0]     r_dataout, w_sync;
  logic [N_CH-1:0]   r_stb;
  logic              w_wr, w_rd, w_usb_oe, w_wrap, w_cap, w_cmd_valid;
  logic              w_cmd_wr, w_cmd_rd, w_data, w_last;
  logic [6:0]        w_cmd_ch, w_cap_ch;
  logic [CH_W-1:0]   w_sel;
  logic [7:0]        w_rd_byte;

  usb_io_sync2 #(.W(DW)) u_sync (
    .clk (CLK_USB),
    .rst (RST),
    .i_d (bus.datain),
    .o_q (w_sync)
  );

  // A host write always wins the bus, so a read is only honoured with FWRn high.
  assign w_wr        = !bus.USB_FWRn;
  assign w_rd        = !bus.USB_FRDn && bus.USB_FWRn;
  assign w_usb_oe    = w_rd;
  assign w_cmd_ch    = USB_D[CMD_CH_MSB:0];
  assign w_cmd_valid = ({1'b0, w_cmd_ch} < 8'(N_CH));
  assign w_wrap      = w_rd && (r_rbyte == LAST);
  assign w_cap       = w_cmd_rd || w_wrap;
  assign w_cap_ch    = w_cmd_rd ? w_cmd_ch : r_rch;
  assign w_rd_byte   = r_snapshot[r_rbyte*8 +: 8];

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_wr    = 1'b0;
    w_cmd_rd    = 1'b0;
    w_data      = 1'b0;
    w_last      = 1'b0;
    if (w_wr) begin
      case (r_state)
        S_CMD: begin
          if (USB_D[CMD_WR_BIT]) begin
            w_cmd_wr    = 1'b1;
            w_state_nxt = S_WDATA;
          end else begin
            w_cmd_rd    = 1'b1;
          end
        end
        S_WDATA: begin
          w_data = 1'b1;
          if (r_wbyte == LAST) begin
            w_last      = 1'b1;
            w_state_nxt = S_CMD;
          end
        end
        default: w_state_nxt = S_CMD;
      endcase
    end
  end

  // Out-of-range channels match nothing and therefore snapshot as zero.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_cap_ch == 7'(k)) w_sel = w_sync[k*CH_W +: CH_W];
    end
    w_snap_nxt = '0;
    w_snap_nxt[CH_W-1:0] = w_sel;
    w_commit = r_shadow;
    w_commit[(NB-1)*8 +: 8] = USB_D;
  end

  always_ff @(posedge CLK_USB or posedge RST) begin
    if (RST) r_state <= S_CMD;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK_USB or posedge RST) begin
    if (RST) begin
      r_ch       <= '0;
      r_rch      <= '0;
      r_wvalid   <= 1'b0;
      r_wbyte    <= '0;
      r_rbyte    <= '0;
      r_shadow   <= '0;
      r_snapshot <= '0;
      r_dataout  <= {N_CH{RESET_VAL}};
      r_stb      <= '0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_stb <= '0;
      if (w_cmd_wr) begin
        r_ch     <= w_cmd_ch;
        r_wvalid <= w_cmd_valid;
        r_wbyte  <= '0;
      end
      if ((w_cmd_wr || w_cmd_rd) && !w_cmd_valid) r_cmd_err <= 1'b1;
      if (w_data) begin
        r_shadow[r_wbyte*8 +: 8] <= USB_D;
        r_wbyte                  <= r_wbyte + 1'b1;
      end
      if (w_last && r_wvalid) begin
        for (int k = 0; k < N_CH; k++) begin
          if (r_ch == 7'(k)) begin
            r_dataout[k*CH_W +: CH_W] <= w_commit[CH_W-1:0];
            r_stb[k]                  <= 1'b1;
          end
        end
      end
      if (w_cmd_rd) begin
        r_rch   <= w_cmd_ch;
        r_rbyte <= '0;
      end else if (w_rd) begin
        r_rbyte <= w_wrap ? '0 : r_rbyte + 1'b1;
      end
      if (w_cap) r_snapshot <= w_snap_nxt;
    end
  end

  assign USB_D           = w_usb_oe ? w_rd_byte : 8'hzz;
  assign bus.dataout     = r_dataout;
  assign bus.dataout_stb = r_stb;
  assign bus.cmd_err     = r_cmd_err;
endmodule

// File: tb/tb_usb_io_regs.sv
// tb/tb_usb_io_regs.sv - directed self-checking bench for usb_io_regs
`timescale 1ns/1ps
module tb_usb_io_regs;
  localparam int N_CH = 4;
  localparam int CH_W = 16;
  localparam logic [CH_W-1:0] RV = 16'hA5A5;

  logic       clk;
  logic       rst;
  logic       r_drv_en;
  logic [7:0] r_drv;
  wire  [7:0] usb_d;
  int         n_checks;
  int         n_errors;

  usb_io_regs_if #(.N_CH(N_CH), .CH_W(CH_W)) bus ();

  usb_io_regs #(.N_CH(N_CH), .CH_W(CH_W), .RESET_VAL(RV)) dut (
    .CLK_USB (clk),
    .RST     (rst),
    .USB_D   (usb_d),
    .bus     (bus)
  );

  assign usb_d = r_drv_en ? r_drv : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    bus.USB_FWRn = 1'b0;
    r_drv_en     = 1'b1;
    r_drv        = b;
    @(posedge clk);
    #1;
    bus.USB_FWRn = 1'b1;
    r_drv_en     = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    @(negedge clk);
    bus.USB_FRDn = 1'b0;
    #1;
    check(tag, {56'd0, usb_d}, {56'd0, exp});
    @(posedge clk);
    #1;
    bus.USB_FRDn = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    r_drv_en = 1'b0;
    r_drv = 8'h00;
    bus.USB_FWRn = 1'b1;
    bus.USB_FRDn = 1'b1;
    bus.datain = '0;
    idle(2);
    check("rst_dataout", bus.dataout, 64'hA5A5_A5A5_A5A5_A5A5);
    check("rst_stb", {60'd0, bus.dataout_stb}, 64'h0);
    check("rst_err", {63'd0, bus.cmd_err}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    wr(8'h80); wr(8'hCD); wr(8'hAB);
    check("wr0_data", bus.dataout, 64'hA5A5_A5A5_A5A5_ABCD);
    check("wr0_stb", {60'd0, bus.dataout_stb}, 64'h1);
    idle(1);
    check("wr0_stb_off", {60'd0, bus.dataout_stb}, 64'h0);

    // Reset lands between the two data bytes of a write.
    wr(8'h80); wr(8'h11);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_data", bus.dataout, 64'hA5A5_A5A5_A5A5_A5A5);
    check("midrst_stb", {60'd0, bus.dataout_stb}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    wr(8'h81); wr(8'h22); wr(8'h33);
    check("after_rst_data", bus.dataout, 64'hA5A5_A5A5_3322_A5A5);
    check("after_rst_stb", {60'd0, bus.dataout_stb}, 64'h2);

    wr(8'h82); wr(8'h34);
    check("wr2_partial", bus.dataout, 64'hA5A5_A5A5_3322_A5A5);
    check("wr2_partial_stb", {60'd0, bus.dataout_stb}, 64'h0);
    wr(8'h12);
    check("wr2_data", bus.dataout, 64'hA5A5_1234_3322_A5A5);
    check("wr2_stb", {60'd0, bus.dataout_stb}, 64'h4);
    idle(1);
    check("wr2_stb_off", {60'd0, bus.dataout_stb}, 64'h0);

    bus.datain[31:16] = 16'hBEEF;
    idle(3);
    wr(8'h01);
    rd("rd_lo", 8'hEF);
    bus.datain[31:16] = 16'h0000;
    idle(3);
    rd("rd_hi_tearfree", 8'hBE);
    bus.datain[31:16] = 16'h7E3C;
    idle(3);
    rd("rd_wrap_lo", 8'h00);
    rd("rd_wrap_hi", 8'h00);
    rd("rd_wrap2_lo", 8'h3C);

    check("err_before", {63'd0, bus.cmd_err}, 64'h0);
    wr(8'h85); wr(8'h77); wr(8'h66);
    check("err_data", bus.dataout, 64'hA5A5_1234_3322_A5A5);
    check("err_stb", {60'd0, bus.dataout_stb}, 64'h0);
    check("err_flag", {63'd0, bus.cmd_err}, 64'h1);
    wr(8'h07);
    rd("err_rd", 8'h00);

    bus.datain[63:48] = 16'h4321;
    idle(3);
    wr(8'h03);
    @(negedge clk);
    bus.USB_FWRn = 1'b0;
    bus.USB_FRDn = 1'b0;
    r_drv_en     = 1'b1;
    r_drv        = 8'h83;
    #1;
    check("coll_oe", {63'd0, dut.w_usb_oe}, 64'h0);
    @(posedge clk);
    #1;
    bus.USB_FWRn = 1'b1;
    bus.USB_FRDn = 1'b1;
    r_drv_en     = 1'b0;
    wr(8'hEE); wr(8'hDD);
    check("coll_data", bus.dataout, 64'hDDEE_1234_3322_A5A5);
    check("coll_stb", {60'd0, bus.dataout_stb}, 64'h8);
    rd("coll_rd_lo", 8'h21);
    rd("coll_rd_hi", 8'h43);

    wr(8'h80); wr(8'h99);
    rd("mix_rd", 8'h21);
    wr(8'h88);
    check("mix_data", bus.dataout, 64'hDDEE_1234_3322_8899);
    check("mix_stb", {60'd0, bus.dataout_stb}, 64'h1);
    check("err_sticky", {63'd0, bus.cmd_err}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
